apb_coeff_loader: RTL and testbench
===================================

APB_COEFF_LOADER -- requirements
Module: apb_coeff_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 8, register address width
- PDATA_WIDTH, 32, read-data width
- COEFF_WIDTH, 20, coefficient width, signed
- COMP, 4, number of slave selects
- CNT_WIDTH, 8, width of the word-count field
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, synchronous active-low reset
- start, in, 1, one-cycle load request
- target, in, 2, slave index; drives MSELx = 1 << target
- base_addr, in, ADDR_WIDTH, first register address
- count, in, CNT_WIDTH, number of words to load
- coeff_valid, in, 1, stream word valid
- coeff_data, in, COEFF_WIDTH, stream word
- coeff_ready, out, 1, loader accepts a stream word
- busy, out, 1, high in every state except IDLE
- done, out, 1, one-cycle completion pulse
- error, out, 1, sticky readback-mismatch flag
- MTRANS, MWRITE, out, 1 each, transfer strobe and direction
- MSELx, out, COMP, one-hot slave select
- MADDR, out, ADDR_WIDTH, address
- MWDATA, out, COEFF_WIDTH, write data
- MRDATA, in, PDATA_WIDTH, read data
REQ-003 The design SHALL have one clock, clk, and a synchronous active-low reset, rst_n.

Function
REQ-004 FSM states SHALL be IDLE, WRITE, RDREQ, RDCHK and DONE, with RDREQ and RDCHK present only under the macro.
REQ-005 In IDLE, start=1 SHALL latch target, base_addr and count, clear error and the checksum, and go to WRITE; if count=0 it SHALL go directly to DONE.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 In WRITE, coeff_ready SHALL be 1, and each coeff_valid&&coeff_ready handshake SHALL produce exactly one write beat on the next cycle.
REQ-008 A write beat SHALL be one cycle with MTRANS=1, MWRITE=1, MSELx=one-hot(target), MADDR=base_addr+index and MWDATA equal to the accepted word.
REQ-009 Address arithmetic SHALL be modulo 2^ADDR_WIDTH, so 8'hFF+1 wraps to 8'h00.
REQ-010 Outside beats, MTRANS, MWRITE and MSELx SHALL be 0, and MADDR and MWDATA SHALL hold their last values.
REQ-011 coeff_ready SHALL drop in the cycle after the count-th handshake, and no extra word SHALL be accepted.
REQ-012 The write checksum SHALL be the XOR of all accepted words.
REQ-013 After the last write beat, the FSM SHALL go to RDREQ when the macro is set, else to DONE.
REQ-014 A read beat SHALL be one cycle with MTRANS=1 and MWRITE=0; MRDATA SHALL be sampled exactly one cycle later, in RDCHK.
REQ-015 Readback SHALL walk all count addresses from base_addr and XOR MRDATA[COEFF_WIDTH-1:0] into the read checksum, alternating RDREQ and RDCHK.
REQ-016 After the last RDCHK, error SHALL be set if the two checksums differ.
REQ-017 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-018 error SHALL be valid at the done pulse and SHALL hold until the next accepted start or reset.
REQ-019 Latency for count=N with coeff_valid held high SHALL be N+2 cycles from start to done without the macro and 3N+2 cycles with it.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force IDLE and set all outputs to 0, including MADDR and MWDATA.
REQ-021 Reset SHALL take priority over start and over any beat in progress, and a partially loaded table SHALL NOT be resumed after reset.

Configuration
REQ-022 Macro APB_COEFF_LOADER_READBACK_EN, when defined, SHALL compile in RDREQ, RDCHK, the read checksum and the MRDATA sampling logic.
REQ-023 When APB_COEFF_LOADER_READBACK_EN is undefined, MTRANS SHALL only rise together with MWRITE=1, error SHALL be tied to 0, and MRDATA SHALL be unused.

Structure
REQ-024 Shared package dfe_cfg_pkg SHALL hold the loader state enum typedef, the target encodings (FRAC_DECI=0, IIR_24=1, IIR_5_1=2, CIC=3) and the default widths.
REQ-025 The design SHALL have one sub-module, apb_beat_gen, which registers MTRANS, MWRITE, MSELx, MADDR and MWDATA from FSM beat requests.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, one line each: stimulus -> required response.
- target=0, base=0x10, count=3, words 1,2,3 back-to-back -> writes at 0x10/0x11/0x12 with MSELx=4'b0001; done at cycle 5 (no macro).
- base=0xFE, count=3 -> MADDR sequence 0xFE, 0xFF, 0x00.
- count=0 start -> done two cycles later, zero MTRANS beats, error=0.
- coeff_valid toggled 1,0,1,0 -> beats only on handshakes; second start mid-load ignored.
- Macro on, slave echoes data -> error=0; slave corrupts one bit of the word at 0x11 -> error=1 at done, cleared by next start.
- rst_n=0 during the second beat -> next cycle all outputs 0, IDLE, coeff_ready=0.

Source files
------------

// File: rtl/dfe_cfg_pkg.sv
// dfe_cfg_pkg: shared DFE configuration types for the coefficient loader
// Holds the loader state enum, the slave target encodings and the default widths.
// RDREQ/RDCHK exist only when APB_COEFF_LOADER_READBACK_EN is defined.
package dfe_cfg_pkg;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_PDATA_WIDTH = 32;
  localparam int DEF_COEFF_WIDTH = 20;
  localparam int DEF_COMP        = 4;
  localparam int DEF_CNT_WIDTH   = 8;
  typedef enum logic [1:0] {
    FRAC_DECI = 2'd0,
    IIR_24    = 2'd1,
    IIR_5_1   = 2'd2,
    CIC       = 2'd3
  } target_e;
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    DONE
`ifdef APB_COEFF_LOADER_READBACK_EN
    , RDREQ,
    RDCHK
`endif
  } loader_state_e;
endpackage

// File: rtl/apb_coeff_loader_if.sv
// apb_coeff_loader_if: register bus between the coefficient loader and the DFE slaves
// Signals: MTRANS/MWRITE strobe and direction, MSELx one-hot select, MADDR, MWDATA, MRDATA.
// master drives the strobes/address/data and reads MRDATA; slave is the mirror.
interface apb_coeff_loader_if #(
  parameter int ADDR_WIDTH  = dfe_cfg_pkg::DEF_ADDR_WIDTH,
  parameter int PDATA_WIDTH = dfe_cfg_pkg::DEF_PDATA_WIDTH,
  parameter int COEFF_WIDTH = dfe_cfg_pkg::DEF_COEFF_WIDTH,
  parameter int COMP        = dfe_cfg_pkg::DEF_COMP
);
  logic                   MTRANS;
  logic                   MWRITE;
  logic [COMP-1:0]        MSELx;
  logic [ADDR_WIDTH-1:0]  MADDR;
  logic [COEFF_WIDTH-1:0] MWDATA;
  logic [PDATA_WIDTH-1:0] MRDATA;
  modport master (output MTRANS, MWRITE, MSELx, MADDR, MWDATA, input MRDATA);
  modport slave  (input MTRANS, MWRITE, MSELx, MADDR, MWDATA, output MRDATA);
endinterface

// File: rtl/apb_beat_gen.sv
// apb_beat_gen: registers one-cycle bus beats requested by the loader FSM
// Ports: clk, rst_n (sync, active-low), wr_req/rd_req beat requests, sel slave index,
// addr/data beat payload, bus (master modport). MADDR/MWDATA hold between beats.
module apb_beat_gen #(
  parameter int ADDR_WIDTH  = dfe_cfg_pkg::DEF_ADDR_WIDTH,
  parameter int COEFF_WIDTH = dfe_cfg_pkg::DEF_COEFF_WIDTH,
  parameter int COMP        = dfe_cfg_pkg::DEF_COMP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic [1:0]             sel,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [COEFF_WIDTH-1:0] data,
  apb_coeff_loader_if.master     bus
);
  logic beat;
  assign beat = wr_req || rd_req;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.MTRANS <= 1'b0;
      bus.MWRITE <= 1'b0;
      bus.MSELx  <= '0;
      bus.MADDR  <= '0;
      bus.MWDATA <= '0;
    end else begin
      bus.MTRANS <= beat;
      bus.MWRITE <= wr_req;
      bus.MSELx  <= beat ? COMP'(1) << sel : '0;
      if (beat) bus.MADDR <= addr;
      if (wr_req) bus.MWDATA <= data;
    end
  end
endmodule

// File: rtl/apb_coeff_loader.sv
// apb_coeff_loader: streams a coefficient table into one DFE slave over the register bus
// Ports: clk, rst_n (sync, active-low); start/target/base_addr/count load request;
// coeff_valid/coeff_data/coeff_ready word stream; busy, done pulse, sticky error;
// bus (master modport) carrying MTRANS/MWRITE/MSELx/MADDR/MWDATA/MRDATA.
// Optional readback-and-compare is compiled in by APB_COEFF_LOADER_READBACK_EN.
module apb_coeff_loader
  import dfe_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int PDATA_WIDTH = DEF_PDATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int COMP        = DEF_COMP,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             target,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [CNT_WIDTH-1:0]   count,
  input  logic                   coeff_valid,
  input  logic [COEFF_WIDTH-1:0] coeff_data,
  output logic                   coeff_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  apb_coeff_loader_if.master     bus
);
  loader_state_e          state, nxt;
  logic [1:0]             tgt_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [CNT_WIDTH-1:0]   cnt_q, idx_q;
  logic [COEFF_WIDTH-1:0] wr_sum;
  logic                   done_q, hs, last, accept, rd_req;
  assign coeff_ready = state == WRITE;
  assign hs          = coeff_valid && coeff_ready;
  assign busy        = state != IDLE;
  assign done        = done_q;
  assign accept      = state == IDLE && start;
  // idx_q counts words written, then is reused to walk the readback addresses
  assign last        = idx_q == cnt_q - CNT_WIDTH'(1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (count == '0 ? DONE : WRITE) : IDLE;
`ifdef APB_COEFF_LOADER_READBACK_EN
      WRITE: nxt = hs && last ? RDREQ : WRITE;
      RDREQ: nxt = RDCHK;
      RDCHK: nxt = last ? DONE : RDREQ;
`else
      WRITE: nxt = hs && last ? DONE : WRITE;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      tgt_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      wr_sum <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= state == DONE;
      if (accept) begin
        tgt_q  <= target;
        base_q <= base_addr;
        cnt_q  <= count;
        idx_q  <= '0;
        wr_sum <= '0;
      end
      if (hs) begin
        wr_sum <= wr_sum ^ coeff_data;
        idx_q  <= last ? '0 : idx_q + CNT_WIDTH'(1);
      end
`ifdef APB_COEFF_LOADER_READBACK_EN
      if (state == RDCHK) idx_q <= idx_q + CNT_WIDTH'(1);
`endif
    end
  end
`ifdef APB_COEFF_LOADER_READBACK_EN
  logic [COEFF_WIDTH-1:0] rd_sum, rd_word;
  logic                   err_q;
  assign rd_req  = state == RDREQ;
  // the read beat is on the bus during RDCHK, so MRDATA is captured at its end
  assign rd_word = bus.MRDATA[COEFF_WIDTH-1:0];
  assign error   = err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_sum <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        rd_sum <= '0;
        err_q  <= 1'b0;
      end
      if (state == RDCHK) begin
        rd_sum <= rd_sum ^ rd_word;
        if (last) err_q <= (rd_sum ^ rd_word) != wr_sum;
      end
    end
  end
`else
  assign rd_req = 1'b0;
  assign error  = 1'b0;
`endif
  apb_beat_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .COMP       (COMP)
  ) u_beat (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_req(hs),
    .rd_req(rd_req),
    .sel   (tgt_q),
    .addr  (base_q + ADDR_WIDTH'(idx_q)),
    .data  (coeff_data),
    .bus   (bus)
  );
endmodule

// File: tb/tb_apb_coeff_loader.sv
// tb_apb_coeff_loader: scoreboard bench for apb_coeff_loader (directed loads, wrap, gaps, readback, reset)
module tb_apb_coeff_loader;
`ifdef APB_COEFF_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [7:0]  addr;
    logic [19:0] data;
  } beat_t;
  logic        clk = 0, rst_n = 0, start = 0, coeff_valid = 0;
  logic [1:0]  target = 0;
  logic [7:0]  base_addr = 0, count = 0;
  logic [19:0] coeff_data = 0;
  logic        coeff_ready, busy, done, error;
  bit          corrupt = 0;
  int          checks = 0, failures = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [19:0] words [16];
  logic [19:0] mem [256];
  beat_t       exp_beats[$];
  logic        exp_err[$];
  beat_t       b;
  apb_coeff_loader_if bus();
  apb_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .base_addr(base_addr),
    .count(count), .coeff_valid(coeff_valid), .coeff_data(coeff_data),
    .coeff_ready(coeff_ready), .busy(busy), .done(done), .error(error), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // slave echoes stored words; corrupt flips bit 0 of the word at 0x11
  assign bus.MRDATA = {12'b0, mem[bus.MADDR] ^ ((corrupt && bus.MADDR == 8'h11) ? 20'h1 : 20'h0)};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.MTRANS === 1'b1) begin
      if (exp_beats.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got addr %0h write %0b expected no beat", bus.MADDR, bus.MWRITE);
      end else begin
        b = exp_beats.pop_front();
        chk("beat_write", 32'(bus.MWRITE), 32'(b.wr));
        chk("beat_sel", 32'(bus.MSELx), 32'(b.sel));
        chk("beat_addr", 32'(bus.MADDR), 32'(b.addr));
        if (b.wr) chk("beat_data", 32'(bus.MWDATA), 32'(b.data));
      end
      if (bus.MWRITE) mem[bus.MADDR] = bus.MWDATA;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_err.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else chk("done_error", 32'(error), 32'(exp_err.pop_front()));
    end
  end
  task automatic run_load(input logic [1:0] tgt, input logic [7:0] base, input int n,
                          input bit gaps, input bit dup, input bit exp_e);
    int k = 0, t = 0, d0, s_cyc;
    bit hs, dup_done = 0;
    for (int i = 0; i < n; i++) exp_beats.push_back('{1'b1, 4'(1 << tgt), base + 8'(i), words[i]});
    if (RB) for (int i = 0; i < n; i++) exp_beats.push_back('{1'b0, 4'(1 << tgt), base + 8'(i), 20'h0});
    exp_err.push_back(exp_e);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1; target = tgt; base_addr = base; count = 8'(n);
    coeff_valid = 1; coeff_data = words[0]; s_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    while (k < n && t < 100) begin
      @(negedge clk);
      hs = coeff_valid && coeff_ready;
      if (t == 0) chk("error_cleared", 32'(error), 0);
      @(posedge clk); #1;
      t++;
      start = 0;
      if (hs) begin
        k++;
        coeff_data = words[k % 16];
      end
      if (gaps) coeff_valid = ~coeff_valid;
      if (dup && k == 1 && !dup_done) begin
        start = 1; target = 3; base_addr = 8'h80; count = 8'd5; dup_done = 1;
      end
    end
    chk("load_handshakes", 32'(k), 32'(n));
    coeff_valid = 1;
    @(negedge clk);
    chk("ready_after_last", 32'(coeff_ready), 0);
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    coeff_valid = 0;
    chk("done_seen", 32'(done_cnt - d0), 1);
    if (!gaps) chk("latency", 32'(done_cyc - s_cyc), RB ? 32'(3 * n + 2) : 32'(n + 2));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) words[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mtrans", 32'(bus.MTRANS), 0);
    chk("rst_mwrite", 32'(bus.MWRITE), 0);
    chk("rst_msel", 32'(bus.MSELx), 0);
    chk("rst_maddr", 32'(bus.MADDR), 0);
    chk("rst_mwdata", 32'(bus.MWDATA), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(coeff_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    @(posedge clk); #1;
    rst_n = 1;
    words[0] = 20'd1; words[1] = 20'd2; words[2] = 20'd3;
    run_load(2'd0, 8'h10, 3, 0, 0, 0);
    @(negedge clk);
    chk("hold_maddr", 32'(bus.MADDR), 32'h12);
    chk("hold_mwdata", 32'(bus.MWDATA), 32'h3);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_mtrans", 32'(bus.MTRANS), 0);
    words[0] = 20'h7FFFF; words[1] = 20'h80000; words[2] = 20'hABCDE;
    run_load(2'd1, 8'hFE, 3, 0, 0, 0);
    run_load(2'd2, 8'h20, 0, 0, 0, 0);
    words[0] = 20'h11111; words[1] = 20'h22222; words[2] = 20'h33333; words[3] = 20'h44444;
    run_load(2'd2, 8'h30, 4, 1, 1, 0);
    words[0] = 20'h0A5A5; words[1] = 20'h5A5A0; words[2] = 20'hFFFFF;
    run_load(2'd3, 8'h10, 3, 0, 0, 0);
    corrupt = 1;
    run_load(2'd3, 8'h10, 3, 0, 0, RB);
    repeat (3) @(negedge clk);
    chk("error_hold", 32'(error), 32'(RB));
    corrupt = 0;
    run_load(2'd3, 8'h10, 3, 0, 0, 0);
    words[0] = 20'h00C0D; words[1] = 20'h0BEEF; words[2] = 20'h01234; words[3] = 20'h05678;
    exp_beats.push_back('{1'b1, 4'b0100, 8'h40, words[0]});
    exp_beats.push_back('{1'b1, 4'b0100, 8'h41, words[1]});
    @(posedge clk); #1;
    start = 1; target = 2; base_addr = 8'h40; count = 8'd4; coeff_valid = 1; coeff_data = words[0];
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    coeff_data = words[1];
    @(posedge clk); #1;
    rst_n = 0;
    coeff_data = words[2];
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_mtrans", 32'(bus.MTRANS), 0);
    chk("mid_rst_mwrite", 32'(bus.MWRITE), 0);
    chk("mid_rst_msel", 32'(bus.MSELx), 0);
    chk("mid_rst_maddr", 32'(bus.MADDR), 0);
    chk("mid_rst_mwdata", 32'(bus.MWDATA), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(coeff_ready), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("no_resume_ready", 32'(coeff_ready), 0);
    chk("no_resume_busy", 32'(busy), 0);
    coeff_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("beats_drained", 32'(exp_beats.size()), 0);
    chk("dones_drained", 32'(exp_err.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
